// File: rtl/xillybus_read_arbiter_if.sv
// Bundle of the source-side ready/valid lanes and the Xillybus 32-bit read
// pipe. The arbiter uses the master view; the environment uses the slave view.
interface xillybus_read_arbiter_if #(
  parameter int N_SRC = 4
);
  logic [N_SRC-1:0]    src_valid;
  logic [32*N_SRC-1:0] src_data;
  logic [N_SRC-1:0]    src_last;
  logic [N_SRC-1:0]    src_ready;
  logic                stream_end;
  logic                user_r_read_32_rden;
  logic [31:0]         user_r_read_32_data;
  logic                user_r_read_32_empty;
  logic                user_r_read_32_eof;
  logic                user_r_read_32_open;

  modport master (
    input  src_valid, src_data, src_last, stream_end,
    input  user_r_read_32_rden, user_r_read_32_open,
    output src_ready, user_r_read_32_data, user_r_read_32_empty, user_r_read_32_eof
  );

  modport slave (
    output src_valid, src_data, src_last, stream_end,
    output user_r_read_32_rden, user_r_read_32_open,
    input  src_ready, user_r_read_32_data, user_r_read_32_empty, user_r_read_32_eof
  );
endinterface

// File: rtl/xillybus_read_arbiter.sv
// Round-robin arbiter multiplexing N_SRC packet sources onto the Xillybus
// 32-bit read pipe. Every grant is framed as header, data words, trailer and
// queued in a small output FIFO read with non-FWFT semantics.
module xillybus_read_arbiter #(
  parameter int N_SRC     = 4,
  parameter int BURST_MAX = 256,
  parameter int OUT_DEPTH = 4
) (
  input  logic                   bus_clk,
  input  logic                   reset,
  xillybus_read_arbiter_if.master bus
);
  // A single source still needs a 1-bit grant register.
  localparam int GW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_DATA, S_TAIL} state_t;

  state_t        state_reg, state_next;
  logic [GW-1:0] grant_reg, grant_next;
  logic [GW-1:0] rr_ptr_reg, rr_ptr_next;
  logic [GW-1:0] grant_inc;
  logic [15:0]   cnt_reg, cnt_next;
  logic          last_flag_reg, last_flag_next;

  logic [31:0]   fifo_mem [OUT_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [31:0]   data_reg;
  logic          eof_reg;

  logic          open, full, empty, push, pop, accept;
  logic [31:0]   push_word;
  logic          hi_hit, lo_hit, scan_hit;
  logic [GW-1:0] hi_idx, lo_idx, scan_idx;
  logic [31:0]   src_word [N_SRC];

  assign open  = bus.user_r_read_32_open;
  assign full  = (count_reg == CW'(OUT_DEPTH));
  assign empty = (count_reg == '0);
  assign pop   = bus.user_r_read_32_rden && !empty;

  assign grant_inc = (grant_reg == GW'(N_SRC - 1)) ? '0 : grant_reg + GW'(1);

  // Unpack the flat source data bus and build the per-source ready lines;
  // ready never looks at src_valid.
  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
    assign src_word[gi] = bus.src_data[32*gi +: 32];
    assign bus.src_ready[gi] = (state_reg == S_DATA) && (grant_reg == GW'(gi)) && open && !full;
  end

  assign accept = (state_reg == S_DATA) && open && !full && bus.src_valid[grant_reg];

  // Cyclic scan from rr_ptr: prefer the lowest requester at/above the pointer,
  // otherwise wrap to the lowest requester overall.
  always_comb begin
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (bus.src_valid[i]) begin
        lo_hit = 1'b1;
        lo_idx = GW'(i);
        if (GW'(i) >= rr_ptr_reg) begin
          hi_hit = 1'b1;
          hi_idx = GW'(i);
        end
      end
    end
    scan_hit = hi_hit || lo_hit;
    scan_idx = hi_hit ? hi_idx : lo_idx;
  end

  // Next-state and push generation for the framing FSM.
  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    rr_ptr_next    = rr_ptr_reg;
    cnt_next       = cnt_reg;
    last_flag_next = last_flag_reg;
    push           = 1'b0;
    push_word      = '0;
    if (!open) begin
      // Host closed the file: abandon the burst and move past this source.
      state_next = S_IDLE;
      cnt_next   = '0;
      if (state_reg != S_IDLE) begin
        rr_ptr_next = grant_inc;
      end
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (scan_hit) begin
            grant_next     = scan_idx;
            last_flag_next = 1'b0;
            state_next     = S_HEAD;
          end
        end
        S_HEAD: begin
          if (!full) begin
            push       = 1'b1;
            push_word  = {16'hA55A, 8'h00, 8'(grant_reg)};
            state_next = S_DATA;
          end
        end
        S_DATA: begin
          if (accept) begin
            push      = 1'b1;
            push_word = src_word[grant_reg];
            cnt_next  = cnt_reg + 16'd1;
            if (bus.src_last[grant_reg]) begin
              last_flag_next = 1'b1;
              state_next     = S_TAIL;
            end else if ((cnt_reg + 16'd1) == 16'(BURST_MAX)) begin
              last_flag_next = 1'b0;
              state_next     = S_TAIL;
            end
          end
        end
        S_TAIL: begin
          if (!full) begin
            push        = 1'b1;
            push_word   = {4'hE, 3'b000, last_flag_reg, 8'(grant_reg), cnt_reg};
            state_next  = S_IDLE;
            rr_ptr_next = grant_inc;
            cnt_next    = '0;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // FSM and arbitration registers.
  always_ff @(posedge bus_clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      grant_reg     <= '0;
      rr_ptr_reg    <= '0;
      cnt_reg       <= '0;
      last_flag_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      rr_ptr_reg    <= rr_ptr_next;
      cnt_reg       <= cnt_next;
      last_flag_reg <= last_flag_next;
    end
  end

  // FIFO storage: plain write port so it can map onto RAM.
  always_ff @(posedge bus_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= push_word;
    end
  end

  // FIFO pointers/count and the registered read word; closing flushes.
  always_ff @(posedge bus_clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      data_reg   <= '0;
    end else begin
      if (pop) begin
        data_reg <= fifo_mem[rd_ptr_reg];
      end
      if (!open) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
        case ({push, pop})
          2'b10:   count_reg <= count_reg + CW'(1);
          2'b01:   count_reg <= count_reg - CW'(1);
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  // Sticky end-of-file once everything is drained and nobody is requesting.
  always_ff @(posedge bus_clk) begin
    if (reset || !open) begin
      eof_reg <= 1'b0;
    end else if (bus.stream_end && (state_reg == S_IDLE) && empty && !(|bus.src_valid)) begin
      eof_reg <= 1'b1;
    end
  end

  assign bus.user_r_read_32_data  = data_reg;
  assign bus.user_r_read_32_empty = empty;
  assign bus.user_r_read_32_eof   = eof_reg;
endmodule

// File: tb/tb_xillybus_read_arbiter.sv
// Bench for xillybus_read_arbiter: table-driven single-source packets,
// hand-written round-robin/backpressure/close/EOF sequences, and randomized
// traffic checked against a packet-level model of the framed host stream.
`timescale 1ns/1ps
module tb_xillybus_read_arbiter;
  localparam int N_SRC     = 4;
  localparam int BURST_MAX = 4;
  localparam int OUT_DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xillybus_read_arbiter_if #(.N_SRC(N_SRC)) bus ();

  xillybus_read_arbiter #(
    .N_SRC(N_SRC), .BURST_MAX(BURST_MAX), .OUT_DEPTH(OUT_DEPTH)
  ) dut (
    .bus_clk(clk),
    .reset  (rst),
    .bus    (bus)
  );

  typedef struct {
    int src;
    int len;
    int exp_first;
    int exp_n;
  } vec_t;

  logic [32:0] src_q [N_SRC][$];   // {last, data} words each source still holds
  logic [32:0] mq    [N_SRC][$];   // model copy
  logic [31:0] got[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_tab[$];
  vec_t        vecs[4];
  int          acc_cnt[N_SRC];
  logic [N_SRC-1:0] acc_pend = '0;
  logic        pop_pend = 1'b0;
  int          rd_mode = 0;        // 0 idle, 1 pop every cycle, 2 random pops
  logic        open_ctl = 1'b1;
  logic        close_req = 1'b0;
  logic        stream_end_ctl = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;
  int          onehot_viol = 0;
  int          model_rr = 0;

  // Source and host behaviour: drive on the falling edge, then record what
  // the coming rising edge will transfer.
  always @(negedge clk) begin
    logic [32:0] w;
    for (int i = 0; i < N_SRC; i++) begin
      if (acc_pend[i]) begin
        void'(src_q[i].pop_front());
        acc_cnt[i]++;
      end
    end
    if (pop_pend) got.push_back(bus.user_r_read_32_data);
    if (close_req && acc_cnt[1] >= 1) begin
      open_ctl  = 1'b0;
      close_req = 1'b0;
    end
    bus.user_r_read_32_open = open_ctl;
    bus.stream_end          = stream_end_ctl;
    for (int i = 0; i < N_SRC; i++) begin
      if (src_q[i].size() > 0) begin
        w = src_q[i][0];
        bus.src_valid[i] = 1'b1;
        bus.src_last[i]  = w[32];
        bus.src_data[32*i +: 32] = w[31:0];
      end else begin
        bus.src_valid[i] = 1'b0;
        bus.src_last[i]  = 1'b0;
        bus.src_data[32*i +: 32] = 32'h0;
      end
    end
    bus.user_r_read_32_rden = (rd_mode == 1) ? 1'b1 :
                              (rd_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    #1;
    if ($countones(bus.src_ready) > 1) onehot_viol++;
    acc_pend = bus.src_ready & bus.src_valid;
    pop_pend = bus.user_r_read_32_rden && !bus.user_r_read_32_empty;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic load(input int src, input int len);
    for (int k = 0; k < len; k++)
      src_q[src].push_back({(k == len - 1), 32'(32'h11 * (k + 1))});
  endtask

  // Wait (bounded) for the host to collect exp_q.size() words, then compare.
  task automatic cmp_got(input string name, input int budget);
    int c = 0;
    while (got.size() < exp_q.size() && c < budget) begin
      tick(1);
      c++;
    end
    if (got.size() < exp_q.size()) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: got %0d words, expected %0d", name, got.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < got.size(); k++)
      check($sformatf("%s word %0d", name, k), got[k], exp_q[k]);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
    $fatal(1);
  end

  initial begin
    int g, n;
    logic lf;
    logic [32:0] w;

    vecs[0] = '{src: 2, len: 3, exp_first: 0,  exp_n: 5};   // plain packet
    vecs[1] = '{src: 1, len: 6, exp_first: 5,  exp_n: 10};  // cut by burst cap
    vecs[2] = '{src: 0, len: 1, exp_first: 15, exp_n: 3};   // single word
    vecs[3] = '{src: 3, len: 4, exp_first: 18, exp_n: 6};   // last lands on cap
    exp_tab = '{32'hA55A0002, 32'h11, 32'h22, 32'h33, 32'hE1020003,
                32'hA55A0001, 32'h11, 32'h22, 32'h33, 32'h44, 32'hE0010004,
                32'hA55A0001, 32'h55, 32'h66, 32'hE1010002,
                32'hA55A0000, 32'h11, 32'hE1000001,
                32'hA55A0003, 32'h11, 32'h22, 32'h33, 32'h44, 32'hE1030004};

    // Reset state
    tick(3);
    check("reset src_ready", 32'(bus.src_ready), 32'h0);
    check("reset empty", 32'(bus.user_r_read_32_empty), 32'h1);
    check("reset eof", 32'(bus.user_r_read_32_eof), 32'h0);
    check("reset data", bus.user_r_read_32_data, 32'h0);
    rst = 1'b0;
    tick(2);

    // Round-robin from rr_ptr 0: 0,1,3 then 0 again only after 3
    got.delete();
    src_q[0].push_back({1'b1, 32'hA0});
    src_q[0].push_back({1'b1, 32'hA1});
    src_q[1].push_back({1'b1, 32'hB0});
    src_q[3].push_back({1'b1, 32'hD0});
    rd_mode = 1;
    exp_q = '{32'hA55A0000, 32'hA0, 32'hE1000001, 32'hA55A0001, 32'hB0, 32'hE1010001,
              32'hA55A0003, 32'hD0, 32'hE1030001, 32'hA55A0000, 32'hA1, 32'hE1000001};
    cmp_got("rr", 200);
    $display("round-robin: %0d words read", got.size());
    tick(3);

    // Table-driven single-source packets
    foreach (vecs[v]) begin
      got.delete();
      exp_q.delete();
      for (int k = 0; k < vecs[v].exp_n; k++) exp_q.push_back(exp_tab[vecs[v].exp_first + k]);
      load(vecs[v].src, vecs[v].len);
      rd_mode = 1;
      cmp_got($sformatf("vec%0d", v), 200);
      tick(4);
      check($sformatf("vec%0d extra words", v), 32'(got.size()), 32'(vecs[v].exp_n));
      check($sformatf("vec%0d empty after", v), 32'(bus.user_r_read_32_empty), 32'h1);
      check($sformatf("vec%0d src_ready idle", v), 32'(bus.src_ready), 32'h0);
      $display("vec %0d: src %0d len %0d -> %0d words read", v, vecs[v].src, vecs[v].len, got.size());
    end

    // Backpressure: host stalls, FIFO fills with header + 3 words
    rd_mode = 0;
    got.delete();
    acc_cnt[0] = 0;
    load(0, 6);
    tick(12);
    check("bp src_ready", 32'(bus.src_ready), 32'h0);
    check("bp empty", 32'(bus.user_r_read_32_empty), 32'h0);
    check("bp accepted", 32'(acc_cnt[0]), 32'd3);
    tick(5);
    check("bp still held", 32'(acc_cnt[0]), 32'd3);
    rd_mode = 1;
    exp_q = '{32'hA55A0000, 32'h11, 32'h22, 32'h33, 32'h44, 32'hE0000004,
              32'hA55A0000, 32'h55, 32'h66, 32'hE1000002};
    cmp_got("bp", 200);
    $display("backpressure: %0d words read", got.size());
    tick(3);

    // Close mid-burst after header + 1 word, reopen: next source wins
    got.delete();
    acc_cnt[1] = 0;
    load(1, 5);
    close_req = 1'b1;
    begin
      int c = 0;
      while (open_ctl && c < 50) begin
        tick(1);
        c++;
      end
    end
    check("close empty", 32'(bus.user_r_read_32_empty), 32'h1);
    check("close src_ready", 32'(bus.src_ready), 32'h0);
    check("close accepted", 32'(acc_cnt[1]), 32'd1);
    check("close words left", 32'(src_q[1].size()), 32'd4);
    tick(3);
    src_q[2].push_back({1'b1, 32'h77});
    tick(2);
    got.delete();
    open_ctl = 1'b1;
    exp_q = '{32'hA55A0002, 32'h77, 32'hE1020001,
              32'hA55A0001, 32'h22, 32'h33, 32'h44, 32'h55, 32'hE1010004};
    cmp_got("reopen", 200);
    $display("close/reopen: %0d words read", got.size());
    tick(3);

    // EOF only once drained and idle; sticky; cleared by close and reset
    rd_mode = 0;
    got.delete();
    src_q[0].push_back({1'b1, 32'hE0});
    tick(10);
    stream_end_ctl = 1'b1;
    tick(3);
    check("eof with 3 queued", 32'(bus.user_r_read_32_eof), 32'h0);
    rd_mode = 1;
    tick(1);
    rd_mode = 0;
    tick(3);
    check("eof with 2 queued", 32'(bus.user_r_read_32_eof), 32'h0);
    rd_mode = 1;
    tick(6);
    rd_mode = 0;
    check("eof drained", 32'(bus.user_r_read_32_eof), 32'h1);
    exp_q = '{32'hA55A0000, 32'hE0, 32'hE1000001};
    cmp_got("eof words", 5);
    stream_end_ctl = 1'b0;
    tick(3);
    check("eof sticky", 32'(bus.user_r_read_32_eof), 32'h1);
    open_ctl = 1'b0;
    tick(2);
    check("eof cleared by close", 32'(bus.user_r_read_32_eof), 32'h0);
    open_ctl = 1'b1;
    stream_end_ctl = 1'b1;
    tick(3);
    check("eof reasserted", 32'(bus.user_r_read_32_eof), 32'h1);
    rst = 1'b1;
    tick(1);
    check("eof cleared by reset", 32'(bus.user_r_read_32_eof), 32'h0);
    stream_end_ctl = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(2);
    $display("eof sequence done");

    // Randomized traffic against the packet-level model (rr_ptr is 0 after reset)
    model_rr = 0;
    for (int r = 0; r < 6; r++) begin
      got.delete();
      exp_q.delete();
      for (int s = 0; s < N_SRC; s++) begin
        int np;
        np = $urandom_range(0, 2);
        for (int p = 0; p < np; p++) begin
          int len;
          len = $urandom_range(1, 7);
          for (int k = 0; k < len; k++) begin
            w = {(k == len - 1), 32'($urandom)};
            mq[s].push_back(w);
            src_q[s].push_back(w);
          end
        end
      end
      // Model: grant first non-empty source from the pointer, frame up to BURST_MAX words
      forever begin
        g = -1;
        for (int k = 0; k < N_SRC; k++)
          if (g < 0 && mq[(model_rr + k) % N_SRC].size() > 0) g = (model_rr + k) % N_SRC;
        if (g < 0) break;
        exp_q.push_back({16'hA55A, 8'h00, 8'(g)});
        n = 0;
        lf = 1'b0;
        forever begin
          w = mq[g].pop_front();
          exp_q.push_back(w[31:0]);
          n++;
          if (w[32]) begin
            lf = 1'b1;
            break;
          end
          if (n == BURST_MAX) break;
        end
        exp_q.push_back({4'hE, 3'b000, lf, 8'(g), 16'(n)});
        model_rr = (g + 1) % N_SRC;
      end
      rd_mode = 2;
      cmp_got($sformatf("rand%0d", r), 3000);
      $display("random round %0d: %0d words expected, %0d read", r, exp_q.size(), got.size());
      tick(8);
    end
    rd_mode = 0;
    check("src_ready one-hot violations", 32'(onehot_viol), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
